// File: rtl/sent_pkg.sv
// Shared constants, FSM state encoding and the CRC-4 nibble step for the SENT receiver.
// Optional build macro SENT_RX_PAUSE_EN adds the PAUSE state.
package sent_pkg;

  localparam logic [4:0]  CRC4_POLY = 5'b11101;
  localparam logic [3:0]  CRC4_SEED = 4'b0101;
  localparam int unsigned SYNC_MIN  = 55;
  localparam int unsigned SYNC_MAX  = 57;
  localparam int unsigned NIB_MIN   = 12;
  localparam int unsigned NIB_MAX   = 27;
  localparam int unsigned DATA_W    = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    STATUS,
    DATA,
    CRC
`ifdef SENT_RX_PAUSE_EN
    , PAUSE
`endif
  } sent_state_e;

  // One nibble through x^4+x^3+x^2+1, MSB first.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      c = {c[2:0], nib[i]} ^ (c[3] ? CRC4_POLY[3:0] : 4'b0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/sent_rx_crc4.sv
// Running CRC-4 register for SENT data nibbles; final_crc_o is the augmented
// (zero-nibble stepped) value compared against the received CRC nibble.
module sent_rx_crc4
  import sent_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_i,
  input  logic       step_i,
  input  logic [3:0] nib_i,
  output logic [3:0] final_crc_o
);

  logic [3:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 4'h0;
    end else if (seed_i) begin
      crc_q <= CRC4_SEED;
    end else if (step_i) begin
      crc_q <= crc4_step(crc_q, nib_i);
    end
  end

  assign final_crc_o = crc4_step(crc_q, 4'h0);

endmodule

// File: rtl/sent_rx_frame_decoder.sv
// SENT receive frame decoder: measures falling-edge intervals in ticks, decodes
// sync/status/data/CRC nibbles and publishes CRC-checked frames.
// Optional build macro SENT_RX_PAUSE_EN accepts a pause pulse after the CRC nibble.
module sent_rx_frame_decoder
  import sent_pkg::*;
#(
  parameter int unsigned TICK_CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic              sent_in,
  input  logic [1:0]        nibble_sel,
  output logic              frame_valid,
  output logic [3:0]        status_nibble,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        crc_rx,
  output logic              crc_err,
  output logic              sync_err,
  output logic              nibble_err
);

  localparam logic [TICK_CNT_W-1:0] CNT_MAX = '1;

  sent_state_e           state_q;
  logic                  sent_q;
  logic [TICK_CNT_W-1:0] cnt_q;
  logic [1:0]            sel_q;
  logic [2:0]            nib_idx_q;
  logic                  crc_done_q;
  logic [3:0]            status_sh_q;
  logic [DATA_W-1:0]     data_sh_q;
  logic                  frame_valid_q, crc_err_q, sync_err_q, nibble_err_q;
  logic [3:0]            status_q, crc_rx_q;
  logic [DATA_W-1:0]     data_q;

  logic       fall_c, sat_c, is_sync_c, is_nib_c, sync_ok_c, step_c;
  logic [3:0] nib_c, final_crc_c;
  logic [2:0] nib_last_c;

  // Interval classification; cnt_q is the completed interval on a falling edge.
  always_comb begin
    fall_c     = sent_q & ~sent_in;
    sat_c      = (cnt_q == CNT_MAX);
    is_sync_c  = (32'(cnt_q) >= SYNC_MIN) && (32'(cnt_q) <= SYNC_MAX);
    is_nib_c   = (32'(cnt_q) >= NIB_MIN) && (32'(cnt_q) <= NIB_MAX);
    nib_c      = 4'(32'(cnt_q) - NIB_MIN);
    case (sel_q)
      2'b00:   nib_last_c = 3'd2;
      2'b01:   nib_last_c = 3'd3;
      default: nib_last_c = 3'd5;
    endcase
    sync_ok_c = fall_c && is_sync_c &&
                ((state_q == WAIT_SYNC) || ((state_q == CRC) && crc_done_q)
`ifdef SENT_RX_PAUSE_EN
                 || (state_q == PAUSE)
`endif
                );
    step_c    = fall_c && is_nib_c && (state_q == DATA);
  end

  sent_rx_crc4 u_crc (
    .clk         (clk),
    .reset       (reset),
    .seed_i      (sync_ok_c),
    .step_i      (step_c),
    .nib_i       (nib_c),
    .final_crc_o (final_crc_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sent_q        <= 1'b1;
      cnt_q         <= '0;
      sel_q         <= 2'b00;
      nib_idx_q     <= 3'd0;
      crc_done_q    <= 1'b0;
      status_sh_q   <= 4'h0;
      data_sh_q     <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      nibble_err_q  <= 1'b0;
      status_q      <= 4'h0;
      crc_rx_q      <= 4'h0;
      data_q        <= '0;
    end else begin
      sent_q        <= sent_in;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      nibble_err_q  <= 1'b0;

      if (fall_c) begin
        cnt_q <= tick_en ? TICK_CNT_W'(1) : '0;
      end else if (tick_en && !sat_c) begin
        cnt_q <= cnt_q + TICK_CNT_W'(1);
      end

      if (sync_ok_c) begin
        sel_q      <= nibble_sel;
        nib_idx_q  <= 3'd0;
        crc_done_q <= 1'b0;
        data_sh_q  <= '0;
        state_q    <= STATUS;
      end else begin
        case (state_q)
          IDLE: if (fall_c) state_q <= WAIT_SYNC;
          WAIT_SYNC: ;
          STATUS: begin
            if (sat_c || (fall_c && !is_nib_c)) begin
              nibble_err_q <= 1'b1;
              state_q      <= WAIT_SYNC;
            end else if (fall_c) begin
              status_sh_q <= nib_c;
              state_q     <= DATA;
            end
          end
          DATA: begin
            if (sat_c || (fall_c && !is_nib_c)) begin
              nibble_err_q <= 1'b1;
              state_q      <= WAIT_SYNC;
            end else if (fall_c) begin
              data_sh_q <= {data_sh_q[DATA_W-5:0], nib_c};
              nib_idx_q <= nib_idx_q + 3'd1;
              if (nib_idx_q == nib_last_c) state_q <= CRC;
            end
          end
          CRC: begin
            // crc_done_q splits the CRC nibble from the interval that must follow it.
            if (!crc_done_q) begin
              if (sat_c || (fall_c && !is_nib_c)) begin
                nibble_err_q <= 1'b1;
                state_q      <= WAIT_SYNC;
              end else if (fall_c) begin
                crc_done_q <= 1'b1;
                crc_rx_q   <= nib_c;
                if (nib_c == final_crc_c) begin
                  frame_valid_q <= 1'b1;
                  status_q      <= status_sh_q;
                  data_q        <= data_sh_q;
                end else begin
                  crc_err_q <= 1'b1;
                end
              end
            end else if (fall_c) begin
`ifdef SENT_RX_PAUSE_EN
              if (32'(cnt_q) >= NIB_MIN) begin
                state_q <= PAUSE;
              end else begin
                sync_err_q <= 1'b1;
                state_q    <= WAIT_SYNC;
              end
`else
              sync_err_q <= 1'b1;
              state_q    <= WAIT_SYNC;
`endif
            end
          end
`ifdef SENT_RX_PAUSE_EN
          PAUSE: begin
            if (fall_c) begin
              sync_err_q <= 1'b1;
              state_q    <= WAIT_SYNC;
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign frame_valid   = frame_valid_q;
  assign status_nibble = status_q;
  assign data_out      = data_q;
  assign crc_rx        = crc_rx_q;
  assign crc_err       = crc_err_q;
  assign sync_err      = sync_err_q;
  assign nibble_err    = nibble_err_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Self-checking bench for sent_rx_frame_decoder: randomized tick spacing and frames
// checked against a table-driven SENT CRC model and a frame-level expectation model.
module tb_sent_rx_frame_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_en = 1'b0;
  logic        sent_in = 1'b1;
  logic [1:0]  nibble_sel = 2'b00;
  logic        frame_valid, crc_err, sync_err, nibble_err;
  logic [3:0]  status_nibble, crc_rx;
  logic [23:0] data_out;

  sent_rx_frame_decoder #(.TICK_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .sent_in(sent_in), .nibble_sel(nibble_sel),
    .frame_valid(frame_valid), .status_nibble(status_nibble), .data_out(data_out), .crc_rx(crc_rx),
    .crc_err(crc_err), .sync_err(sync_err), .nibble_err(nibble_err)
  );

  always #5 clk = ~clk;

  // SENT CRC-4 lookup: entry k is (k * x^4) mod (x^4+x^3+x^2+1).
  localparam logic [3:0] CRC_TBL [16] = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                                          4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

  int unsigned n_vec = 0, n_bad = 0;
  int unsigned cyc = 0, fv_cyc = 0, ce_cyc = 0, last_fall_cyc = 0;
  int unsigned fv_n = 0, ce_n = 0, se_n = 0, ne_n = 0;
  int unsigned fv0, ce0, se0, ne0;
  logic        scramble = 1'b0;
  logic [3:0]  exp_status = 4'h0, exp_crc = 4'h0;
  logic [23:0] exp_data = 24'h0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin fv_n = fv_n + 1; fv_cyc = cyc; end
    if (crc_err)     begin ce_n = ce_n + 1; ce_cyc = cyc; end
    if (sync_err)    se_n = se_n + 1;
    if (nibble_err)  ne_n = ne_n + 1;
  end

  function automatic logic [3:0] crc_ref(input logic [23:0] dw, input int n);
    logic [3:0] c;
    c = 4'd5;
    for (int i = 0; i < n; i++) c = CRC_TBL[c] ^ dw[4*(n-1-i) +: 4];
    return CRC_TBL[c];
  endfunction

  function automatic int nib_count(input logic [1:0] sel);
    return (sel == 2'b00) ? 3 : (sel == 2'b01) ? 4 : 6;
  endfunction

  task automatic snap();
    fv0 = fv_n; ce0 = ce_n; se0 = se_n; ne0 = ne_n;
  endtask

  // One interval of n ticks: falling edge on the first tick, low for 4 ticks, then high.
  task automatic send_iv(input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(1, 3));
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        tick_en = (c == 0);
        sent_in = (k >= 4);
        if (k == 0 && c == 0) last_fall_cyc = cyc;
        if (scramble && k == 1 && c == 0) nibble_sel = 2'($urandom);
      end
    end
  endtask

  // Status, data and CRC nibbles of a frame whose sync interval is already in progress.
  task automatic send_body(input logic [1:0] sel, input logic [3:0] st, input logic [23:0] dw,
                           input int n, input logic [3:0] crc);
    nibble_sel = sel;
    scramble = 1'b1;
    send_iv(12 + int'(st));
    scramble = 1'b0;
    for (int i = 0; i < n; i++) send_iv(12 + int'(dw[4*(n-1-i) +: 4]));
    send_iv(12 + int'(crc));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; tick_en = 1'b0; sent_in = 1'b1; scramble = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b exp 0", frame_valid); end
    n_vec++; if (status_nibble !== 4'h0) begin n_bad++; $display("FAIL reset_status: got %h exp 0", status_nibble); end
    n_vec++; if (data_out !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h exp 0", data_out); end
    n_vec++; if (crc_rx !== 4'h0) begin n_bad++; $display("FAIL reset_crc: got %h exp 0", crc_rx); end
    n_vec++; if ({crc_err, sync_err, nibble_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_errs: got %b exp 000", {crc_err, sync_err, nibble_err}); end
    send_iv(20);
    send_iv(56);
  endtask

  task automatic test_fixed_vectors();
    snap();
    send_body(2'b00, 4'h0, 24'h000, 3, 4'h9);
    send_iv(56);
    n_vec++; if (fv_n - fv0 !== 1) begin n_bad++; $display("FAIL fixed0_fv: got %0d pulses exp 1", fv_n - fv0); end
    n_vec++; if (fv_cyc !== last_fall_cyc + 1) begin
      n_bad++; $display("FAIL fixed0_latency: got cycle %0d exp %0d", fv_cyc, last_fall_cyc + 1); end
    n_vec++; if (data_out !== 24'h0) begin n_bad++; $display("FAIL fixed0_data: got %h exp 000000", data_out); end
    n_vec++; if (crc_rx !== 4'h9) begin n_bad++; $display("FAIL fixed0_crc: got %h exp 9", crc_rx); end

    snap();
    send_body(2'b00, 4'h3, 24'h2C7, 3, 4'h6);
    send_iv(56);
    n_vec++; if (fv_n - fv0 !== 1) begin n_bad++; $display("FAIL fixed1_fv: got %0d pulses exp 1", fv_n - fv0); end
    n_vec++; if (status_nibble !== 4'h3) begin n_bad++; $display("FAIL fixed1_status: got %h exp 3", status_nibble); end
    n_vec++; if (data_out !== 24'h0002C7) begin n_bad++; $display("FAIL fixed1_data: got %h exp 0002c7", data_out); end

    snap();
    send_body(2'b00, 4'h3, 24'h2C7, 3, 4'h7);
    send_iv(56);
    n_vec++; if (ce_n - ce0 !== 1 || fv_n - fv0 !== 0) begin
      n_bad++; $display("FAIL fixed2_pulses: got crc_err %0d fv %0d exp 1 0", ce_n - ce0, fv_n - fv0); end
    n_vec++; if (ce_cyc !== last_fall_cyc + 1) begin
      n_bad++; $display("FAIL fixed2_latency: got cycle %0d exp %0d", ce_cyc, last_fall_cyc + 1); end
    n_vec++; if (data_out !== 24'h0002C7 || status_nibble !== 4'h3) begin
      n_bad++; $display("FAIL fixed2_hold: got %h/%h exp 0002c7/3", data_out, status_nibble); end
    n_vec++; if (crc_rx !== 4'h7) begin n_bad++; $display("FAIL fixed2_crc: got %h exp 7", crc_rx); end
    exp_status = 4'h3; exp_data = 24'h0002C7; exp_crc = 4'h7;
  endtask

  task automatic test_bad_nibble();
    logic [23:0] dw;
    logic [3:0]  st;
    snap();
    nibble_sel = 2'b00;
    send_iv(12 + 5);
    send_iv(12 + 9);
    send_iv(30);
    send_iv(56);
    st = 4'($urandom);
    dw = 24'($urandom) & 24'hFFFF;
    send_body(2'b01, st, dw, 4, crc_ref(dw, 4));
    send_iv(56);
    exp_status = st; exp_data = dw; exp_crc = crc_ref(dw, 4);
    n_vec++; if (ne_n - ne0 !== 1) begin n_bad++; $display("FAIL badnib_ne: got %0d pulses exp 1", ne_n - ne0); end
    n_vec++; if (fv_n - fv0 !== 1) begin n_bad++; $display("FAIL badnib_fv: got %0d pulses exp 1", fv_n - fv0); end
    n_vec++; if (data_out !== exp_data || status_nibble !== exp_status || crc_rx !== exp_crc) begin
      n_bad++; $display("FAIL badnib_out: got %h/%h/%h exp %h/%h/%h",
                        data_out, status_nibble, crc_rx, exp_data, exp_status, exp_crc); end
  endtask

  task automatic test_pause();
    logic [23:0] dw;
    int unsigned exp_se;
`ifdef SENT_RX_PAUSE_EN
    exp_se = 0;
`else
    exp_se = 1;
`endif
    snap();
    dw = 24'($urandom);
    send_body(2'b10, 4'hA, dw, 6, crc_ref(dw, 6));
    send_iv(100);
    send_iv(56);
    dw = 24'($urandom) & 24'hFFF;
    send_body(2'b00, 4'h5, dw, 3, crc_ref(dw, 3));
    send_iv(56);
    exp_status = 4'h5; exp_data = dw; exp_crc = crc_ref(dw, 3);
    n_vec++; if (se_n - se0 !== exp_se) begin n_bad++; $display("FAIL pause_se: got %0d exp %0d", se_n - se0, exp_se); end
    n_vec++; if (fv_n - fv0 !== 2 || ne_n - ne0 !== 0) begin
      n_bad++; $display("FAIL pause_pulses: got fv %0d ne %0d exp 2 0", fv_n - fv0, ne_n - ne0); end
    n_vec++; if (data_out !== exp_data || status_nibble !== exp_status) begin
      n_bad++; $display("FAIL pause_out: got %h/%h exp %h/%h", data_out, status_nibble, exp_data, exp_status); end
  endtask

  task automatic test_random_frames();
    logic [1:0]  sel;
    logic [3:0]  st, good, crc;
    logic [23:0] dw;
    int          n;
    bit          ok;
    for (int f = 0; f < 12; f++) begin
      sel  = 2'($urandom);
      n    = nib_count(sel);
      st   = 4'($urandom);
      dw   = 24'($urandom) & ((24'h1 << (4 * n)) - 24'h1);
      good = crc_ref(dw, n);
      ok   = ($urandom_range(0, 3) != 0);
      crc  = ok ? good : (good ^ 4'($urandom_range(1, 15)));
      snap();
      send_body(sel, st, dw, n, crc);
      send_iv(56);
      exp_crc = crc;
      if (ok) begin exp_status = st; exp_data = dw; end
      n_vec++; if (fv_n - fv0 !== (ok ? 1 : 0) || ce_n - ce0 !== (ok ? 0 : 1)) begin
        n_bad++; $display("FAIL rand%0d_pulses: got fv %0d ce %0d exp good=%0d", f, fv_n - fv0, ce_n - ce0, ok); end
      n_vec++; if (data_out !== exp_data) begin
        n_bad++; $display("FAIL rand%0d_data: got %h exp %h", f, data_out, exp_data); end
      n_vec++; if (status_nibble !== exp_status || crc_rx !== exp_crc) begin
        n_bad++; $display("FAIL rand%0d_stcrc: got %h/%h exp %h/%h", f, status_nibble, crc_rx, exp_status, exp_crc); end
      n_vec++; if (se_n - se0 !== 0 || ne_n - ne0 !== 0) begin
        n_bad++; $display("FAIL rand%0d_errs: got se %0d ne %0d exp 0 0", f, se_n - se0, ne_n - ne0); end
    end
  endtask

  task automatic test_saturation();
    snap();
    nibble_sel = 2'b00;
    send_iv(12 + 1);
    send_iv(12 + 2);
    send_iv(300);
    n_vec++; if (ne_n - ne0 !== 1) begin n_bad++; $display("FAIL sat_ne: got %0d pulses exp 1", ne_n - ne0); end
    n_vec++; if (fv_n - fv0 !== 0 || data_out !== exp_data || crc_rx !== exp_crc) begin
      n_bad++; $display("FAIL sat_hold: got fv %0d data %h crc %h exp 0 %h %h",
                        fv_n - fv0, data_out, crc_rx, exp_data, exp_crc); end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] dw;
    send_iv(56);
    nibble_sel = 2'b01;
    send_iv(12 + 4);
    send_iv(12 + 7);
    snap();
    apply_reset();
    n_vec++; if (data_out !== 24'h0 || status_nibble !== 4'h0 || crc_rx !== 4'h0 || frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_out: got %h/%h/%h/%b exp 0", data_out, status_nibble, crc_rx, frame_valid); end
    send_iv(20);
    send_iv(56);
    n_vec++; if (fv_n + ce_n + se_n + ne_n !== fv0 + ce0 + se0 + ne0) begin
      n_bad++; $display("FAIL midrst_pulses: got %0d extra pulses exp 0", (fv_n + ce_n + se_n + ne_n) - (fv0 + ce0 + se0 + ne0)); end
    snap();
    dw = 24'($urandom) & 24'hFFFF;
    send_body(2'b01, 4'hC, dw, 4, crc_ref(dw, 4));
    send_iv(56);
    n_vec++; if (fv_n - fv0 !== 1 || data_out !== dw || status_nibble !== 4'hC) begin
      n_bad++; $display("FAIL midrst_recover: got fv %0d data %h st %h exp 1 %h c", fv_n - fv0, data_out, status_nibble, dw); end
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_bad_nibble();
    test_pause();
    test_random_frames();
    test_saturation();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sent_rx_frame_decoder.md
SENT_RX_FRAME_DECODER -- requirements
Module: sent_rx_frame_decoder

Interface
REQ-001 Parameter TICK_CNT_W, default 8, SHALL be the width of the saturating tick counter (max count 2^W-1).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port tick_en  input  1  SHALL be a one-cycle pulse per SENT clock tick.
REQ-005 Port sent_in  input  1  SHALL be the SENT line, already synchronized to clk.
REQ-006 Port nibble_sel  input  2  SHALL select the data-nibble count: 00=3, 01=4, 10=6, 11=6.
REQ-007 Port frame_valid  output  1  SHALL pulse when a frame is received with a matching CRC.
REQ-008 Port status_nibble  output  4  SHALL hold the last received status nibble.
REQ-009 Port data_out  output  24  SHALL hold the data nibbles, right-justified, first nibble most significant, unused MSBs zero.
REQ-010 Port crc_rx  output  4  SHALL hold the last received CRC nibble.
REQ-011 Ports crc_err, sync_err, nibble_err  output  1 each  SHALL be one-cycle error pulses.

Function
REQ-012 The block SHALL detect a falling edge when the registered sent_in is 1 and the current sent_in is 0.
REQ-013 The counter SHALL increment on tick_en, saturate at all-ones, and load 0 on a falling edge (load 1 if tick_en is coincident).
REQ-014 On each falling edge, the counter value SHALL be the completed interval.
REQ-015 The FSM SHALL have the states IDLE, WAIT_SYNC, STATUS, DATA and CRC, plus PAUSE when the macro is defined.
REQ-016 IDLE: the first falling edge SHALL move the FSM to WAIT_SYNC, and that interval SHALL be discarded.
REQ-017 WAIT_SYNC: an interval of 55..57 SHALL be accepted as sync, latch nibble_sel, seed the CRC to 4'b0101, and move to STATUS; other intervals SHALL stay in WAIT_SYNC without an error.
REQ-018 A nibble interval SHALL be 12..27 ticks, and the nibble value SHALL be the interval minus 12.
REQ-019 STATUS: a valid nibble SHALL be stored as status and move to DATA; status SHALL be excluded from the CRC.
REQ-020 DATA: each valid nibble SHALL shift into a data shadow register and update the CRC; after the N-th nibble the FSM SHALL move to CRC.
REQ-021 CRC: a valid nibble SHALL be compared with the final CRC, defined as the running CRC stepped once with a zero nibble (polynomial x^4+x^3+x^2+1, seed 0101).
REQ-022 On a CRC match, the block SHALL update status_nibble/data_out/crc_rx and pulse frame_valid for one cycle, registered one cycle after the closing edge.
REQ-023 On a CRC mismatch, the block SHALL update crc_rx only, pulse crc_err with the same timing, and leave data_out and status_nibble unchanged.
REQ-024 After the CRC nibble, the next interval SHALL be sync (go to STATUS) or, if the macro is enabled, a pause; otherwise the block SHALL pulse sync_err and go to WAIT_SYNC.
REQ-025 An invalid interval in STATUS, DATA or CRC SHALL pulse nibble_err and go to WAIT_SYNC.
REQ-026 Counter saturation in STATUS, DATA or CRC SHALL pulse nibble_err immediately, without waiting for an edge, and go to WAIT_SYNC.
REQ-027 A partial frame SHALL never change data_out, status_nibble or crc_rx.
REQ-028 A change of nibble_sel mid-frame SHALL have no effect until the next accepted sync.

Reset
REQ-029 Reset SHALL set state to IDLE, the counter to 0, and the registered sent_in to 1.
REQ-030 Reset SHALL set all outputs to 0; reset mid-frame SHALL discard the frame with no pulses.

Configuration
REQ-031 With SENT_RX_PAUSE_EN defined, a non-sync interval of 12 or more ticks (including saturated) after CRC SHALL be a pause and go to PAUSE.
REQ-032 In PAUSE, the next interval SHALL be sync (go to STATUS), or the block SHALL pulse sync_err and go to WAIT_SYNC.
REQ-033 Without SENT_RX_PAUSE_EN, the PAUSE state SHALL be absent and REQ-024 SHALL apply.

Structure
REQ-034 Package sent_pkg SHALL hold CRC4_POLY=5'b11101, CRC4_SEED=4'b0101, SYNC_MIN=55, SYNC_MAX=57, NIB_MIN=12, NIB_MAX=27 and the FSM state enum.
REQ-035 Sub-module sent_rx_crc4 SHALL hold the CRC register, with seed, nibble-step and final zero-nibble step as a combinational output.

Verification
REQ-036 Sync 56, status 12, data 12,12,12, CRC 21 (0x9), sel=00, closing edge -> frame_valid pulse, data_out=0x000000, crc_rx=0x9.
REQ-037 Sync 56, status 15, data 14,24,19 (0x2C7), CRC 18 (0x6) -> frame_valid pulse, status_nibble=0x3, data_out=0x0002C7.
REQ-038 Same frame as REQ-037 with CRC 19 (0x7) -> crc_err pulse, no frame_valid, data_out retains its prior value, crc_rx=0x7.
REQ-039 Data interval 30 ticks mid-frame, then a clean frame -> nibble_err pulse, no frame_valid for the bad frame, the clean frame is accepted.
REQ-040 After CRC, a 100-tick interval then sync 56 -> with SENT_RX_PAUSE_EN, no error and the next frame is decoded; without the macro, sync_err pulses and decoding resumes at the following sync.
REQ-041 sent_in held high for 300 ticks during DATA -> nibble_err at saturation (count 255); a reset pulse mid-frame clears all outputs.
